sipo_deserializer: RTL and testbench

//   Downstream stage of the PISO shift register: samples its serial stream and rebuilds parallel words.

---
 rtl/sipo_deserializer.sv | 115 +++++++++++
 tb/tb_sipo_deserializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel word rebuilder with valid/ready output and overrun flag (define PARITY_CHECK_EN for even-parity check)
module sipo_deserializer #(
  parameter int N = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         sync,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  input  logic         overrun_clr,
  output logic         parity_err
);
  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LAST = W'(N - 1);
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [N-1:0] sr_q, sr_d, base, shifted, word;
  logic [N-1:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d, overrun_q, overrun_d, start, done, load;
`ifdef PARITY_CHECK_EN
  logic par_bad, parity_err_q, parity_err_d;
`endif
  assign start = bit_valid && (state_q == IDLE || sync);
  assign base = start ? '0 : sr_q;
  assign shifted = MSB_FIRST ? {base[N-2:0], serial_in} : {serial_in, base[N-1:1]};
  // Receive FSM: shift accepted bits, restart on sync, flag completion with the bypassed word
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    done = 1'b0;
    word = shifted;
`ifdef PARITY_CHECK_EN
    par_bad = 1'b0;
`endif
    if (start) begin
      state_d = SHIFT;
      cnt_d = W'(1);
      sr_d = shifted;
    end else if (bit_valid && state_q == SHIFT) begin
      sr_d = shifted;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
`ifdef PARITY_CHECK_EN
        state_d = PARITY;
`else
        state_d = IDLE;
        cnt_d = '0;
        done = 1'b1;
`endif
      end
    end
`ifdef PARITY_CHECK_EN
    else if (bit_valid && state_q == PARITY) begin
      state_d = IDLE;
      cnt_d = '0;
      done = 1'b1;
      word = sr_q;
      par_bad = ^{sr_q, serial_in};
    end
`endif
  end
  assign load = done && (!data_valid_q || data_ready);
  // Output register: load on completion when free or draining, else drop and flag overrun
  always_comb begin
    data_out_d = load ? word : data_out_q;
    data_valid_d = load ? 1'b1 : (data_ready ? 1'b0 : data_valid_q);
    overrun_d = (done && !load) ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
`ifdef PARITY_CHECK_EN
    parity_err_d = load ? par_bad : parity_err_q;
`endif
  end
  // State and output flops, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of word assembly, handshake, overrun, sync and bit order
module tb_sipo_deserializer;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, serial_in = 1'b0, bit_valid = 1'b0, sync = 1'b0;
  logic data_ready = 1'b1, overrun_clr = 1'b0;
  logic [3:0] data_out, data_out_l;
  logic data_valid, overrun, parity_err, data_valid_l, overrun_l, parity_err_l;
  int n_vec = 0, n_err = 0;
  sipo_deserializer #(.N(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid), .sync(sync),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .parity_err(parity_err)
  );
  sipo_deserializer #(.N(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid), .sync(sync),
    .data_out(data_out_l), .data_valid(data_valid_l), .data_ready(data_ready),
    .overrun(overrun_l), .overrun_clr(overrun_clr), .parity_err(parity_err_l)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bit_in(input logic b, input logic s);
    serial_in = b;
    bit_valid = 1'b1;
    sync = s;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sync = 1'b0;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] w, input logic s, input logic r, input logic bp);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && !PAR) data_ready = r;
      bit_in(w[i], s && i == 3);
    end
    if (PAR) begin
      data_ready = r;
      bit_in(^w ^ bp, 1'b0);
    end
  endtask
  initial begin
    #12;
    check("rst_dout", data_out, 4'h0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    reset_n = 1'b1;
    send(4'b1011, 1'b1, 1'b1, 1'b0);
    check("t1_dout", data_out, 4'b1011);
    check("t1_valid", data_valid, 1'b1);
    idle();
    check("t1_valid_drop", data_valid, 1'b0);
    send(4'b1011, 1'b1, 1'b0, 1'b0);
    check("t2_first_valid", data_valid, 1'b1);
    check("t2_first_ovr", overrun, 1'b0);
    send(4'b0110, 1'b1, 1'b0, 1'b0);
    check("t2_dout_held", data_out, 4'b1011);
    check("t2_ovr", overrun, 1'b1);
    overrun_clr = 1'b1;
    idle();
    overrun_clr = 1'b0;
    check("t2_ovr_clr", overrun, 1'b0);
    check("t2_still_valid", data_valid, 1'b1);
    send(4'b0110, 1'b1, 1'b1, 1'b0);
    check("t3_dout", data_out, 4'b0110);
    check("t3_valid", data_valid, 1'b1);
    check("t3_ovr", overrun, 1'b0);
    idle();
    check("t3_valid_drop", data_valid, 1'b0);
    check("t3_dout_kept", data_out, 4'b0110);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    check("t4_partial_no_valid", data_valid, 1'b0);
    send(4'b0011, 1'b1, 1'b1, 1'b0);
    check("t4_sync_dout", data_out, 4'b0011);
    check("t4_sync_valid", data_valid, 1'b1);
    bit_in(1'b1, 1'b1);
    idle();
    bit_in(1'b0, 1'b0);
    idle();
    idle();
    bit_in(1'b1, 1'b0);
    idle();
    bit_in(1'b1, 1'b0);
    if (PAR) bit_in(1'b1, 1'b0);
    check("t4_gap_dout", data_out, 4'b1011);
    check("t4_gap_valid", data_valid, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    reset_n = 1'b0;
    #2;
    check("t5_rst_dout", data_out, 4'h0);
    check("t5_rst_valid", data_valid, 1'b0);
    reset_n = 1'b1;
    send(4'b0101, 1'b0, 1'b1, 1'b0);
    check("t5_dout", data_out, 4'b0101);
    check("t5_valid", data_valid, 1'b1);
    idle();
    send(4'b1000, 1'b1, 1'b1, 1'b0);
    check("t5_msb_dout", data_out, 4'b1000);
    check("t5_lsb_dout", data_out_l, 4'b0001);
    check("t5_lsb_valid", data_valid_l, 1'b1);
    send(4'b1011, 1'b1, 1'b1, 1'b0);
    check("t6_good_perr", parity_err, 1'b0);
    send(4'b1011, 1'b1, 1'b1, 1'b1);
    check("t6_bad_perr", parity_err, PAR);
    check("t6_bad_dout", data_out, 4'b1011);
    check("t6_bad_valid", data_valid, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
